ifid_stage_register: RTL

- Parametrised successor to the fixed IF/ID latch: a phase-gated pipeline register between fetch and decode.
- Adds a valid bit, stall hold, flush with NOP injection, and a one-entry skid buffer with an upstream ready signal.
- Adds a saturating bubble counter.
- Sits between the fetch stage (pc/command/cond producer) and the decode stage.

---
 rtl/ifid_stage_register.sv | 101 ++++++++++
 1 files changed

// File: rtl/ifid_stage_register.sv
// ifid_stage_register
//   Phase-gated pipeline register between fetch and decode. Holds one
//   output entry plus a one-entry skid buffer. The skid catches a fetch
//   beat that arrives while decode stalls. Flush and empty-advance edges
//   inject a NOP bubble and bump a saturating bubble counter.
//
// Ports
//   clock, reset            rising-edge clock, async active-low reset
//   phasecounter            one-hot phase; bit CAPTURE_PHASE enables capture
//   in_pc/in_command/in_cond/in_valid   fetch-side entry
//   in_ready                high when the skid is empty (upstream may send)
//   stall, flush            decode hold request / squash
//   out_pc/out_command/out_cond/out_valid   registered entry to decode
//   bubble_count            saturating count of bubbles issued
module ifid_stage_register #(
  parameter int               PC_W          = 16,
  parameter int               CMD_W         = 16,
  parameter int               COND_W        = 4,
  parameter int               PHASE_W       = 5,
  parameter int               CAPTURE_PHASE = 0,
  parameter logic [CMD_W-1:0] NOP_COMMAND   = '0,
  parameter int               BCNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PHASE_W-1:0] phasecounter,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [CMD_W-1:0]   in_command,
  input  logic [COND_W-1:0]  in_cond,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               stall,
  input  logic               flush,
  output logic [PC_W-1:0]    out_pc,
  output logic [CMD_W-1:0]   out_command,
  output logic [COND_W-1:0]  out_cond,
  output logic               out_valid,
  output logic [BCNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [CMD_W-1:0]  cmd;
    logic [COND_W-1:0] cond;
  } entry_t;

  localparam entry_t NOP_ENTRY = '{pc: '0, cmd: NOP_COMMAND, cond: '0};

  entry_t              out_q, skid_q, in_entry;
  logic                out_vld_q, skid_full;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_inc;
  logic                capture;

  assign in_entry = '{pc: in_pc, cmd: in_command, cond: in_cond};
  assign capture  = phasecounter[CAPTURE_PHASE];
  // Holds at all-ones instead of wrapping.
  assign bcnt_inc = (bcnt_q == '1) ? bcnt_q : bcnt_q + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q     <= NOP_ENTRY;
      out_vld_q <= 1'b0;
      skid_q    <= '0;
      skid_full <= 1'b0;
      bcnt_q    <= '0;
    end else if (capture) begin
      if (flush) begin
        out_q     <= NOP_ENTRY;
        out_vld_q <= 1'b0;
        skid_full <= 1'b0;
        bcnt_q    <= bcnt_inc;
      end else if (stall) begin
        // Outputs hold; park one incoming beat if there is room.
        if (!skid_full && in_valid) begin
          skid_q    <= in_entry;
          skid_full <= 1'b1;
        end
      end else if (skid_full) begin
        // Drain the older parked beat first to keep arrival order.
        out_q     <= skid_q;
        out_vld_q <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_valid) begin
        out_q     <= in_entry;
        out_vld_q <= 1'b1;
      end else begin
        out_q     <= NOP_ENTRY;
        out_vld_q <= 1'b0;
        bcnt_q    <= bcnt_inc;
      end
    end
  end

  assign in_ready     = ~skid_full;
  assign out_pc       = out_q.pc;
  assign out_command  = out_q.cmd;
  assign out_cond     = out_q.cond;
  assign out_valid    = out_vld_q;
  assign bubble_count = bcnt_q;

endmodule
